// File: rtl/ce_multi_gen.sv
// ce_multi_gen: multi-channel clock-enable generator for the board tops.
// Each channel runs either an integer divide-by-(cfg+1) counter or a
// fractional phase accumulator (rate = cfg/2^W), gated by run[i].
// sync clears every phase at once. lvl[i] toggles on each ce[i] pulse.
module ce_multi_gen #(
  parameter int NCH = 3,
  parameter int W = 16,
  parameter logic [NCH*W-1:0] TC_INIT = {16'd33, 16'd9, 16'd1},
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic             cfg_frac,
  input  logic [W-1:0]     cfg_val,
  input  logic [NCH-1:0]   run,
  input  logic             sync,
  output logic [NCH-1:0]   ce,
  output logic [NCH-1:0]   lvl
);

  logic [NCH-1:0]         mode_q, mode_d;
  logic [NCH-1:0][W-1:0]  cfg_q, cfg_d;
  logic [NCH-1:0][W-1:0]  phase_q, phase_d;
  logic [NCH-1:0]         ce_q, ce_d;
  logic [NCH-1:0]         lvl_q, lvl_d;
  logic [W:0]             sum;

  // Per-channel next state. The phase update uses the pre-edge mode/cfg;
  // a config write lands in mode_d/cfg_d and only affects the next edge.
  // Phases are never cleared by a write, so a mode switch simply
  // reinterprets whatever phase value is present.
  always_comb begin
    mode_d  = mode_q;
    cfg_d   = cfg_q;
    phase_d = phase_q;
    ce_d    = '0;
    lvl_d   = lvl_q;
    sum     = '0;
    for (int i = 0; i < NCH; i++) begin
      sum = {1'b0, phase_q[i]} + {1'b0, cfg_q[i]};
      if (sync) begin
        phase_d[i] = '0;
      end else if (run[i]) begin
        if (!mode_q[i]) begin
          // >= rather than == so a lowered terminal count recovers at once
          if (phase_q[i] >= cfg_q[i]) begin
            phase_d[i] = '0;
            ce_d[i]    = 1'b1;
          end else begin
            phase_d[i] = phase_q[i] + W'(1);
          end
        end else begin
          phase_d[i] = sum[W-1:0];
          ce_d[i]    = sum[W];
        end
      end
      if (ce_d[i]) lvl_d[i] = ~lvl_q[i];
      // out-of-range channel indices match no i and are dropped
      if (cfg_we && (cfg_ch == CHW'(i))) begin
        mode_d[i] = cfg_frac;
        cfg_d[i]  = cfg_val;
      end
    end
  end

  // State registers; reset restores integer mode and the build-time counts.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mode_q  <= '0;
      cfg_q   <= TC_INIT;
      phase_q <= '0;
      ce_q    <= '0;
      lvl_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      cfg_q   <= cfg_d;
      phase_q <= phase_d;
      ce_q    <= ce_d;
      lvl_q   <= lvl_d;
    end
  end

  assign ce  = ce_q;
  assign lvl = lvl_q;

endmodule
